mdu_unit: RTL and testbench

// - Multi-cycle multiply/divide unit in the EX stage. Executes mult/multu/div/divu and

---
 rtl/mdu_pkg.sv | 28 ++
 rtl/mdu_unit.sv | 142 ++++++++++++++
 tb/tb_mdu_unit.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: md_op codes, FSM states and
// the MD-class helpers also used by the decoder and hazard unit.
package mdu_pkg;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    // Ops that launch a multi-cycle operation (asserted on start).
    function automatic logic is_md_start(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    // Ops that touch HI/LO without launching, and so must wait until busy drops.
    function automatic logic is_md_read(input logic [2:0] op);
        return (op == MD_MTHI) || (op == MD_MTLO);
    endfunction

endpackage

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit holding HI/LO. Results are computed into
// shadow registers at start and committed to HI/LO when the busy window ends.
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic        we_hilo,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output mdu_state_e  state_dbg
);

    // Handshake: start is a one-cycle request accepted only in IDLE; busy is
    // high from the next cycle for exactly the op's latency, and hi/lo hold the
    // new result in the first cycle busy is low. Upstream must not raise start
    // or we_hilo while busy is high; if it does, they are ignored.

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    mdu_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      hi_n, lo_n;
    logic             skip_commit;
    logic             start_ok, commit, hilo_wr;

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        abs_a, abs_b, div_s_b, div_u_b;
    logic [31:0]        uq_s, ur_s;
    logic [31:0]        res_hi, res_lo;
    logic               is_mult, is_div;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start_ok  = 1'b0;
        commit    = 1'b0;
        hilo_wr   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && is_md_start(md_op)) begin
                    start_ok  = 1'b1;
                    state_nxt = ST_RUN;
                end else if (we_hilo && !start) begin
                    hilo_wr = 1'b1;
                end
            end
            ST_RUN: begin
                if (cnt == '0) begin
                    commit    = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Signed divide works on magnitudes so INT_MIN / -1 wraps to INT_MIN cleanly.
    always_comb begin
        is_mult = (md_op == MD_MULT) || (md_op == MD_MULTU);
        is_div  = (md_op == MD_DIV) || (md_op == MD_DIVU);
        prod_s  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        prod_u  = {32'd0, a} * {32'd0, b};
        abs_a   = a[31] ? (~a + 32'd1) : a;
        abs_b   = b[31] ? (~b + 32'd1) : b;
        div_s_b = (b == 32'd0) ? 32'd1 : abs_b;
        div_u_b = (b == 32'd0) ? 32'd1 : b;
        uq_s    = abs_a / div_s_b;
        ur_s    = abs_a % div_s_b;
        res_hi  = 32'd0;
        res_lo  = 32'd0;
        case (md_op)
            MD_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            MD_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            MD_DIV: begin
                res_lo = (a[31] ^ b[31]) ? (~uq_s + 32'd1) : uq_s;
                res_hi = a[31] ? (~ur_s + 32'd1) : ur_s;
            end
            MD_DIVU: begin
                res_lo = a / div_u_b;
                res_hi = a % div_u_b;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt         <= '0;
            hi_n        <= 32'd0;
            lo_n        <= 32'd0;
            skip_commit <= 1'b0;
            hi          <= 32'd0;
            lo          <= 32'd0;
        end else begin
            if (start_ok) begin
                hi_n        <= res_hi;
                lo_n        <= res_lo;
                skip_commit <= is_div && (b == 32'd0);
                cnt         <= is_mult ? MULT_LOAD : DIV_LOAD;
            end else if (state == ST_RUN && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end

            if (commit && !skip_commit) begin
                hi <= hi_n;
                lo <= lo_n;
            end else if (hilo_wr) begin
                if (md_op == MD_MTHI) hi <= a;
                if (md_op == MD_MTLO) lo <= a;
            end
        end
    end

    assign busy      = (state == ST_RUN);
    assign state_dbg = state;

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed vector table, randomized ops
// against an arithmetic reference model, and hand-written corner sequences.
module tb_mdu_unit;
    import mdu_pkg::*;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [2:0]  md_op;
    logic        we_hilo;
    logic [31:0] a, b;
    logic        busy;
    logic [31:0] hi, lo;
    mdu_state_e  state_dbg;

    int errors = 0;
    int checks = 0;
    int illegal_starts = 0;
    logic [63:0] exp_q[$];
    logic [63:0] m_hilo;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_busy;
    } vec_t;

    vec_t vecs[7];

    mdu_unit #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .md_op     (md_op),
        .we_hilo   (we_hilo),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .hi        (hi),
        .lo        (lo),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Protocol checker: start while an operation is in flight is illegal upstream.
    always @(posedge clk) begin
        if (reset_n && start && busy) illegal_starts++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: 64-bit plain arithmetic on the architectural rules.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] x,
                                          input logic [31:0] y, input logic [63:0] cur);
        longint sx, sy, q, r;
        longint unsigned ux, uy, uq, ur;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (op)
            MD_MULT:  return 64'(sx * sy);
            MD_MULTU: return 64'(ux * uy);
            MD_DIV: begin
                if (y == 32'd0) return cur;
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            MD_DIVU: begin
                if (y == 32'd0) return cur;
                uq = ux / uy;
                ur = ux % uy;
                return {ur[31:0], uq[31:0]};
            end
            default: return cur;
        endcase
    endfunction

    // Driver: called just after a negedge with the unit idle; returns likewise.
    task automatic run_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                          output int nbusy);
        start = 1'b1;
        md_op = op;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
        md_op = MD_NONE;
        nbusy = 0;
        while (busy && nbusy < 100) begin
            nbusy++;
            @(negedge clk);
        end
    endtask

    task automatic write_hilo(input logic [2:0] op, input logic [31:0] x);
        we_hilo = 1'b1;
        md_op   = op;
        a       = x;
        @(negedge clk);
        we_hilo = 1'b0;
        md_op   = MD_NONE;
    endtask

    initial begin
        int nb;
        int busy_seen;
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        logic [63:0] exp;

        vecs[0] = '{MD_MULT,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, MULT_CYCLES};
        vecs[1] = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MULT_CYCLES};
        vecs[2] = '{MD_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_CYCLES};
        vecs[3] = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DIV_CYCLES};
        vecs[4] = '{MD_DIVU,  32'd7,         32'd2,        32'd1,         32'd3,         DIV_CYCLES};
        vecs[5] = '{MD_MULT,  32'd3,         32'd4,        32'd0,         32'd12,        MULT_CYCLES};
        vecs[6] = '{MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, DIV_CYCLES};

        reset_n = 1'b0;
        start   = 1'b0;
        md_op   = MD_NONE;
        we_hilo = 1'b0;
        a       = 32'd0;
        b       = 32'd0;
        m_hilo  = 64'd0;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        check("reset_state", 64'(state_dbg), 64'(ST_IDLE));
        reset_n = 1'b1;
        @(negedge clk);

        // directed vector table
        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, nb);
            m_hilo = model(vecs[i].op, vecs[i].a, vecs[i].b, m_hilo);
            check($sformatf("vec%0d_busy", i), 64'(nb), 64'(vecs[i].exp_busy));
            check($sformatf("vec%0d_hilo", i), {hi, lo}, {vecs[i].exp_hi, vecs[i].exp_lo});
        end

        // randomized ops against the model
        for (int i = 0; i < 24; i++) begin
            rop = 3'($urandom_range(1, 4));
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
            m_hilo = model(rop, ra, rb, m_hilo);
            exp_q.push_back(m_hilo);
            run_op(rop, ra, rb, nb);
            check($sformatf("rnd%0d_busy", i), 64'(nb),
                  64'((rop == MD_MULT || rop == MD_MULTU) ? MULT_CYCLES : DIV_CYCLES));
            exp = exp_q.pop_front();
            check($sformatf("rnd%0d_hilo", i), {hi, lo}, exp);
        end

        // known state, then divu by zero leaves hi/lo alone
        run_op(MD_MULTU, 32'h0001_0000, 32'h0003_0002, nb);
        m_hilo = 64'h0000_0003_0002_0000;
        check("pre_div0_hilo", {hi, lo}, m_hilo);
        run_op(MD_DIVU, 32'd5, 32'd0, nb);
        check("div0_busy", 64'(nb), 64'(DIV_CYCLES));
        check("div0_hilo", {hi, lo}, m_hilo);

        write_hilo(MD_MTHI, 32'h1234);
        check("mthi_hi", 64'(hi), 64'h1234);
        check("mthi_lo", 64'(lo), m_hilo[31:0]);
        check("mthi_busy", 64'(busy), 64'd0);
        write_hilo(MD_MTLO, 32'h55);
        check("mtlo_lo", 64'(lo), 64'h55);
        check("mtlo_hi", 64'(hi), 64'h1234);
        m_hilo = {32'h1234, 32'h55};

        // start and we_hilo together: the start wins
        we_hilo = 1'b1;
        run_op(MD_MULT, 32'd6, 32'd7, nb);
        we_hilo = 1'b0;
        check("start_wins_hilo", {hi, lo}, 64'd42);

        // back-to-back: div started on the first idle cycle after mult
        run_op(MD_MULT, 32'hFFFF_FFFF, 32'd9, nb);
        check("b2b_mult_busy", 64'(nb), 64'(MULT_CYCLES));
        check("b2b_mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF7);
        run_op(MD_DIV, 32'd100, 32'd7, nb);
        check("b2b_div_busy", 64'(nb), 64'(DIV_CYCLES));
        check("b2b_div_hilo", {hi, lo}, {32'd2, 32'd14});

        // start during RUN is ignored and flagged by the checker
        start = 1'b1;
        md_op = MD_MULT;
        a     = 32'd5;
        b     = 32'd6;
        @(negedge clk);
        start = 1'b0;
        nb    = 0;
        while (busy && nb < 100) begin
            nb++;
            if (nb == 2) begin
                start = 1'b1;
                md_op = MD_DIV;
                a     = 32'd1000;
                b     = 32'd3;
            end else begin
                start = 1'b0;
                md_op = MD_NONE;
            end
            @(negedge clk);
        end
        start = 1'b0;
        md_op = MD_NONE;
        check("ign_busy", 64'(nb), 64'(MULT_CYCLES));
        check("ign_hilo", {hi, lo}, 64'd30);
        busy_seen = 0;
        repeat (DIV_CYCLES + 3) begin
            @(negedge clk);
            if (busy) busy_seen++;
        end
        check("ign_no_second_op", 64'(busy_seen), 64'd0);
        check("ign_hilo_after", {hi, lo}, 64'd30);
        check("ign_flagged", 64'(illegal_starts), 64'd1);

        // reset pulsed mid-RUN clears everything and nothing commits later
        start = 1'b1;
        md_op = MD_MULT;
        a     = 32'd3;
        b     = 32'd4;
        @(negedge clk);
        start = 1'b0;
        md_op = MD_NONE;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        busy_seen = 0;
        repeat (MULT_CYCLES + 4) begin
            @(negedge clk);
            if (busy) busy_seen++;
        end
        check("rst_no_busy", 64'(busy_seen), 64'd0);
        check("rst_no_commit", {hi, lo}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
